// File: rtl/wb_select.sv
// wb_select: write-back source mux with load extraction, one-entry
// valid/ready output register.
// Ports: clk, rst_n (async, active low); in_valid/in_ready upstream
// handshake; sel, src (NSRC*DW flattened), ld_size, ld_signed, addr_lo,
// in_rd, in_we from MEM; wb_valid/wb_ready downstream handshake;
// wb_data, wb_rd, wb_we registered results.
// Optional: define WB_SELECT_PERF_EN to add stall_cnt[31:0], a
// saturating count of cycles spent with wb_valid && !wb_ready.
module wb_select #(
  parameter int DW      = 32,
  parameter int NSRC    = 4,
  parameter int MEM_IDX = 1,
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SW-1:0]    sel,
  input  logic [NSRC*DW-1:0] src,
  input  logic [1:0]       ld_size,
  input  logic             ld_signed,
  input  logic [1:0]       addr_lo,
  input  logic [4:0]       in_rd,
  input  logic             in_we,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [DW-1:0]    wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_we
`ifdef WB_SELECT_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  logic [SW-1:0] idx;
  logic [DW-1:0] picked;
  logic [DW-1:0] nxt;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          is_mem;
  logic          xfer_in;

  assign in_ready = !wb_valid || wb_ready;
  assign xfer_in  = in_valid && in_ready;

  // Out-of-range selects fall back to the last source.
  always_comb begin
    idx = sel;
    if (int'(sel) >= NSRC) idx = SW'(NSRC - 1);
  end

  assign picked = src[int'(idx)*DW +: DW];
  assign is_mem = (int'(idx) == MEM_IDX);

  // Half-word lane uses addr_lo[1] only; a misaligned
  // halfword is silently treated as aligned.
  assign byte_v = picked[int'(addr_lo)*8 +: 8];
  assign half_v = picked[int'(addr_lo[1])*16 +: 16];

  always_comb begin
    nxt = picked;
    if (is_mem) begin
      unique case (1'b1)
        (ld_size == 2'b00):
          nxt = {{(DW-8){ld_signed & byte_v[7]}}, byte_v};
        (ld_size == 2'b01):
          nxt = {{(DW-16){ld_signed & half_v[15]}}, half_v};
        default:
          nxt = picked;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      wb_we    <= 1'b0;
    end else if (xfer_in) begin
      wb_valid <= 1'b1;
      wb_data  <= nxt;
      wb_rd    <= in_rd;
      wb_we    <= in_we && (in_rd != 5'd0);
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

`ifdef WB_SELECT_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (wb_valid && !wb_ready
                 && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_select.sv
// tb_wb_select: directed vector table, hand-written handshake and
// reset sequences, then random traffic against a reference model.
module tb_wb_select;

  localparam int DW = 32;
  localparam int NSRC = 3;
  localparam int MI = 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    sel;
  logic [NSRC*DW-1:0] src;
  logic [1:0]    ld_size;
  logic          ld_signed;
  logic [1:0]    addr_lo;
  logic [4:0]    in_rd;
  logic          in_we;
  logic          wb_valid;
  logic          wb_ready;
  logic [DW-1:0] wb_data;
  logic [4:0]    wb_rd;
  logic          wb_we;
`ifdef WB_SELECT_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  wb_select #(
    .DW(DW),
    .NSRC(NSRC),
    .MEM_IDX(MI)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sel(sel),
    .src(src),
    .ld_size(ld_size),
    .ld_signed(ld_signed),
    .addr_lo(addr_lo),
    .in_rd(in_rd),
    .in_we(in_we),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_data(wb_data),
    .wb_rd(wb_rd),
    .wb_we(wb_we)
`ifdef WB_SELECT_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: pick source, then for the memory source cut the
  // lane out arithmetically and sign-extend by subtraction.
  function automatic logic [31:0] ref_data(
    input logic [1:0] s,
    input logic [31:0] a0, input logic [31:0] a1,
    input logic [31:0] a2, input logic [1:0] sz,
    input logic sg, input logic [1:0] ad);
    logic [31:0] w [3];
    int k;
    longint v;
    w[0] = a0;
    w[1] = a1;
    w[2] = a2;
    k = (int'(s) < NSRC) ? int'(s) : NSRC - 1;
    v = longint'(w[k]);
    if (k == MI) begin
      if (sz == 2'b00) begin
        v = (v >> (8 * int'(ad))) % 256;
        if (sg && v >= 128) v = v - 256;
      end else if (sz == 2'b01) begin
        v = (v >> (16 * (int'(ad) / 2))) % 65536;
        if (sg && v >= 32768) v = v - 65536;
      end
    end
    return v[31:0];
  endfunction

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [1:0]  sz;
    logic        sg;
    logic [1:0]  ad;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] ed;
    logic        ew;
  } vec_t;

  vec_t tbl [13];

  logic        ev;
  logic [31:0] ed;
  logic [4:0]  erd;
  logic        ewe;
  logic [31:0] a0, a1, a2;

  initial begin
    tbl[0]  = '{2'd0, 32'h12345678, 32'h0, 32'h0,
                2'b00, 1'b0, 2'd0, 5'd3, 1'b1,
                32'h12345678, 1'b1};
    tbl[1]  = '{2'd1, 32'h0, 32'h80FF7F01, 32'h0,
                2'b00, 1'b1, 2'd3, 5'd4, 1'b1,
                32'hFFFFFF80, 1'b1};
    tbl[2]  = '{2'd1, 32'h0, 32'h80FF7F01, 32'h0,
                2'b00, 1'b0, 2'd3, 5'd4, 1'b1,
                32'h00000080, 1'b1};
    tbl[3]  = '{2'd1, 32'h0, 32'h80FF7F01, 32'h0,
                2'b01, 1'b1, 2'd2, 5'd4, 1'b1,
                32'hFFFF80FF, 1'b1};
    tbl[4]  = '{2'd3, 32'h0, 32'h0, 32'hDEADBEEF,
                2'b00, 1'b1, 2'd1, 5'd5, 1'b1,
                32'hDEADBEEF, 1'b1};
    tbl[5]  = '{2'd2, 32'h0, 32'h0, 32'hDEADBEEF,
                2'b00, 1'b0, 2'd0, 5'd0, 1'b1,
                32'hDEADBEEF, 1'b0};
    tbl[6]  = '{2'd1, 32'h0, 32'h80FF7F01, 32'h0,
                2'b10, 1'b1, 2'd1, 5'd31, 1'b1,
                32'h80FF7F01, 1'b1};
    tbl[7]  = '{2'd1, 32'h0, 32'h80FF7F01, 32'h0,
                2'b00, 1'b1, 2'd0, 5'd6, 1'b0,
                32'h00000001, 1'b0};
    tbl[8]  = '{2'd1, 32'h0, 32'h80FF7F01, 32'h0,
                2'b01, 1'b1, 2'd1, 5'd7, 1'b1,
                32'h00007F01, 1'b1};
    tbl[9]  = '{2'd1, 32'h0, 32'h80FF7F01, 32'h0,
                2'b01, 1'b0, 2'd3, 5'd8, 1'b1,
                32'h000080FF, 1'b1};
    tbl[10] = '{2'd1, 32'h0, 32'h80FF7F01, 32'h0,
                2'b00, 1'b1, 2'd2, 5'd9, 1'b1,
                32'hFFFFFFFF, 1'b1};
    tbl[11] = '{2'd0, 32'hCAFEF00D, 32'h1, 32'h2,
                2'b00, 1'b1, 2'd3, 5'd10, 1'b1,
                32'hCAFEF00D, 1'b1};
    tbl[12] = '{2'd1, 32'h0, 32'h80FF7F01, 32'h0,
                2'b11, 1'b0, 2'd2, 5'd11, 1'b1,
                32'h80FF7F01, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    wb_ready = 1'b0;
    sel = '0;
    src = '0;
    ld_size = '0;
    ld_signed = 1'b0;
    addr_lo = '0;
    in_rd = '0;
    in_we = 1'b0;
    #2;
    check("rst_valid", 32'(wb_valid), 32'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_rd", 32'(wb_rd), 32'd0);
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      sel = tbl[i].sel;
      src = {tbl[i].s2, tbl[i].s1, tbl[i].s0};
      ld_size = tbl[i].sz;
      ld_signed = tbl[i].sg;
      addr_lo = tbl[i].ad;
      in_rd = tbl[i].rd;
      in_we = tbl[i].we;
      in_valid = 1'b1;
      wb_ready = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_valid", i),
            32'(wb_valid), 32'd1);
      check($sformatf("tbl%0d_data", i), wb_data, tbl[i].ed);
      check($sformatf("tbl%0d_rd", i),
            32'(wb_rd), 32'(tbl[i].rd));
      check($sformatf("tbl%0d_we", i),
            32'(wb_we), 32'(tbl[i].ew));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain_valid", 32'(wb_valid), 32'd0);

    // Stall: hold for 4 cycles, then back-to-back transfer.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    sel = 2'd0;
    src = {32'h0, 32'h0, 32'h11111111};
    in_rd = 5'd7;
    in_we = 1'b1;
    in_valid = 1'b1;
    wb_ready = 1'b0;
    @(posedge clk);
    #1;
    check("stall_load_valid", 32'(wb_valid), 32'd1);
    check("stall_load_data", wb_data, 32'h11111111);
    src = {32'h0, 32'h0, 32'h22222222};
    in_rd = 5'd8;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("stall_valid", 32'(wb_valid), 32'd1);
      check("stall_data", wb_data, 32'h11111111);
      check("stall_rd", 32'(wb_rd), 32'd7);
      check("stall_we", 32'(wb_we), 32'd1);
    end
`ifdef WB_SELECT_PERF_EN
    check("stall_cnt4", stall_cnt, 32'd4);
`endif
    wb_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_valid", 32'(wb_valid), 32'd1);
    check("b2b_data", wb_data, 32'h22222222);
    check("b2b_rd", 32'(wb_rd), 32'd8);

    // Asynchronous reset while stalled.
    wb_ready = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_arst_valid", 32'(wb_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(wb_valid), 32'd0);
    check("arst_we", 32'(wb_we), 32'd0);
    check("arst_data", wb_data, 32'd0);
    check("arst_rd", 32'(wb_rd), 32'd0);
`ifdef WB_SELECT_PERF_EN
    check("arst_stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    wb_ready = 1'b1;
    sel = 2'd2;
    src = {32'hA5A5A5A5, 32'h0, 32'h0};
    in_rd = 5'd9;
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(wb_valid), 32'd1);
    check("post_rst_data", wb_data, 32'hA5A5A5A5);

    in_valid = 1'b0;
    @(posedge clk);
    #1;
    ev = 1'b0;
    ed = '0;
    erd = '0;
    ewe = 1'b0;

    for (int n = 0; n < 400; n++) begin
      a0 = $urandom;
      a1 = $urandom;
      a2 = $urandom;
      src = {a2, a1, a0};
      sel = 2'($urandom_range(0, 3));
      ld_size = 2'($urandom_range(0, 3));
      ld_signed = 1'($urandom_range(0, 1));
      addr_lo = 2'($urandom_range(0, 3));
      in_rd = ($urandom_range(0, 7) == 0) ? 5'd0
              : 5'($urandom_range(1, 31));
      in_we = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      wb_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("rnd_in_ready", 32'(in_ready),
            32'(!ev || wb_ready));
      if (in_valid && (!ev || wb_ready)) begin
        ev = 1'b1;
        ed = ref_data(sel, a0, a1, a2, ld_size,
                      ld_signed, addr_lo);
        erd = in_rd;
        ewe = in_we && (in_rd != 5'd0);
      end else if (wb_ready) begin
        ev = 1'b0;
      end
      @(posedge clk);
      #1;
      check("rnd_valid", 32'(wb_valid), 32'(ev));
      if (ev) begin
        check("rnd_data", wb_data, ed);
        check("rnd_rd", 32'(wb_rd), 32'(erd));
        check("rnd_we", 32'(wb_we), 32'(ewe));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/wb_select.md
WB_SELECT -- requirements
Module: wb_select

Interface
REQ-001 Parameter DW, default 32, data width of every source and of wb_data.
REQ-002 Parameter NSRC, default 4, number of write-back sources (minimum 2); SW = max(1, clog2(NSRC)).
REQ-003 Parameter MEM_IDX, default 1, index of the source that carries raw memory load data.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream (MEM stage) presents a result.
REQ-007 in_ready  output  1  stage can accept; equals !wb_valid || wb_ready.
REQ-008 sel  input  SW  source select (MemToReg successor).
REQ-009 src  input  NSRC*DW  flattened sources; source k at bits [k*DW +: DW].
REQ-010 ld_size  input  2  00 byte, 01 half, 10/11 word.
REQ-011 ld_signed  input  1  1 sign-extend, 0 zero-extend.
REQ-012 addr_lo  input  2  low byte address of the load.
REQ-013 in_rd  input  5  destination register.
REQ-014 in_we  input  1  register write request.
REQ-015 wb_valid  output  1  registered result valid.
REQ-016 wb_ready  input  1  register file / downstream accepts.
REQ-017 wb_data  output  DW  registered write-back data.
REQ-018 wb_rd  output  5  registered destination.
REQ-019 wb_we  output  1  registered write enable, qualified as in REQ-025.

Function
REQ-020 Transfer in occurs when in_valid && in_ready; transfer out when wb_valid && wb_ready.
REQ-021 On transfer in, wb_data/wb_rd/wb_we load next cycle; latency exactly 1 cycle.
REQ-022 wb_valid set on transfer in; cleared on transfer out without simultaneous transfer in; simultaneous in/out keeps wb_valid=1 with new data.
REQ-023 While wb_valid && !wb_ready, all wb_* outputs hold stable; in_ready=0.
REQ-024 Selection: sel < NSRC picks src[sel]; sel >= NSRC picks src[NSRC-1].
REQ-025 wb_we = in_we && (in_rd != 0); writes to r0 never asserted.
REQ-026 When selected index == MEM_IDX: byte = bits [addr_lo*8 +: 8], half = bits [addr_lo[1]*16 +: 16], word = full; extended to DW per ld_signed.
REQ-027 Half-word with addr_lo[0]=1 uses addr_lo[1] only (misalignment ignored, not trapped).
REQ-028 Non-memory sources pass unmodified; ld_size/ld_signed/addr_lo ignored.
REQ-029 No combinational path from src/sel to wb_data.

Reset
REQ-030 rst_n low asynchronously clears wb_valid, wb_we, wb_rd=0, wb_data=0, and stall counter (if present).
REQ-031 Reset mid-transfer discards the held result; first accept allowed on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro WB_SELECT_PERF_EN defined: adds output stall_cnt [31:0], incremented each cycle wb_valid && !wb_ready, saturating at 0xFFFFFFFF, reset to 0.
REQ-033 Macro undefined: no stall_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-034 Reset, then in_valid=1, sel=0, src0=0x1234_5678, in_rd=3, in_we=1, wb_ready=1 -> next cycle wb_valid=1, wb_data=0x12345678, wb_rd=3, wb_we=1.
REQ-035 sel=MEM_IDX, src1=0x80FF_7F01, ld_size=00, addr_lo=3, ld_signed=1 -> wb_data=0xFFFFFF80; ld_signed=0 -> 0x00000080; ld_size=01, addr_lo=2, signed -> 0xFFFF80FF.
REQ-036 wb_ready=0 for 4 cycles after a result -> wb_* stable, in_ready=0, stall_cnt=4 (PERF_EN); wb_ready=1 with in_valid=1 -> back-to-back transfer, wb_valid stays 1.
REQ-037 NSRC=3, sel=3, src2=0xDEADBEEF -> wb_data=0xDEADBEEF; in_rd=0, in_we=1 -> wb_we=0.
REQ-038 rst_n pulsed low asynchronously while wb_valid=1, wb_ready=0 -> wb_valid, wb_we, wb_data clear immediately, before next clock edge.
